// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking gate controller: state encoding,
// default capacity/occupancy sizing and a ceiling-log2 helper for timer widths.
package parking_pkg;

    localparam int CAPACITY_DEF = 10;
    localparam int OCC_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_CODE  = 2'd1,
        ENTRY_OPEN = 2'd2,
        EXIT_OPEN  = 2'd3
    } gate_state_t;

    // Bits needed to count 0..v-1; never returns less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_rise_edge_det.sv
// Registered rising-edge detector for one synchronous sensor level.
// rise is high for one cycle, the cycle after d is first sampled high.
module rise_edge_det (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: arbitrates entry/exit requests, tracks occupancy and
// pulses door_open for the blinker. Define PARKING_PASSCODE_EN for keypad-gated entry.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int               CAPACITY     = CAPACITY_DEF,
    parameter int               OCC_W        = OCC_W_DEF,
    parameter int               OPEN_CYCLES  = 50,
    parameter int               CODE_W       = 4,
    parameter logic [CODE_W-1:0] PASSCODE    = 4'hA,
    parameter int               CODE_TIMEOUT = 100
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              car_entry_req,
    input  logic              car_exit_req,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              door_open,
    output logic              gate_busy,
    output logic              full,
    output logic              denied,
    output logic [OCC_W-1:0]  occupancy,
    output gate_state_t       fsm_state
);

    localparam int TMR_MAX = (OPEN_CYCLES > CODE_TIMEOUT) ? OPEN_CYCLES : CODE_TIMEOUT;
    localparam int TMR_W   = clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [OCC_W-1:0] CAP_VAL   = OCC_W'(CAPACITY);

    gate_state_t      state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [OCC_W-1:0] occ_n;
    logic             door_n, denied_n, full_n;
    logic             entry_rise, exit_rise;

    rise_edge_det u_entry_det (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (car_entry_req),
        .rise  (entry_rise)
    );

    rise_edge_det u_exit_det (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (car_exit_req),
        .rise  (exit_rise)
    );

`ifndef PARKING_PASSCODE_EN
    logic unused_code;
    assign unused_code = ^{code_in, code_valid, PASSCODE};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            timer     <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            door_open <= 1'b0;
            denied    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            occupancy <= occ_n;
            full      <= full_n;
            door_open <= door_n;
            denied    <= denied_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer + 1'b1;
        occ_n    = occupancy;
        door_n   = 1'b0;
        denied_n = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                // An exit that can act takes priority; a simultaneous entry edge is lost.
                if (exit_rise && (occupancy != '0)) begin
                    state_n = EXIT_OPEN;
                    door_n  = 1'b1;
                end else if (entry_rise) begin
                    if (full) begin
                        denied_n = 1'b1;
                    end else begin
`ifdef PARKING_PASSCODE_EN
                        state_n = WAIT_CODE;
`else
                        state_n = ENTRY_OPEN;
                        door_n  = 1'b1;
`endif
                    end
                end
            end
`ifdef PARKING_PASSCODE_EN
            WAIT_CODE: begin
                if (code_valid) begin
                    timer_n = '0;
                    if (code_in == PASSCODE) begin
                        state_n = ENTRY_OPEN;
                        door_n  = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        denied_n = 1'b1;
                    end
                end else if (timer == TMR_W'(CODE_TIMEOUT - 1)) begin
                    timer_n  = '0;
                    state_n  = IDLE;
                    denied_n = 1'b1;
                end
            end
`endif
            ENTRY_OPEN: begin
                if (timer == OPEN_LAST) begin
                    timer_n = '0;
                    state_n = IDLE;
                    if (occupancy < CAP_VAL) occ_n = occupancy + 1'b1;
                end
            end
            EXIT_OPEN: begin
                if (timer == OPEN_LAST) begin
                    timer_n = '0;
                    state_n = IDLE;
                    if (occupancy != '0) occ_n = occupancy - 1'b1;
                end
            end
            default: begin
                timer_n = '0;
                state_n = IDLE;
            end
        endcase
        full_n = (occ_n == CAP_VAL);
    end

    assign gate_busy = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed request sequences with a
// queue of expected door_open/denied pulses checked by a negedge monitor.
module tb_parking_gate_ctrl;
    import parking_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        car_entry_req, car_exit_req;
    logic [3:0]  code_in;
    logic        code_valid;
    logic        door_open, gate_busy, full, denied;
    logic [3:0]  occupancy;
    gate_state_t fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_q[$];
    logic [3:0]  model_occ;
    int          cyc;

    parking_gate_ctrl dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .car_entry_req (car_entry_req),
        .car_exit_req  (car_exit_req),
        .code_in       (code_in),
        .code_valid    (code_valid),
        .door_open     (door_open),
        .gate_busy     (gate_busy),
        .full          (full),
        .denied        (denied),
        .occupancy     (occupancy),
        .fsm_state     (fsm_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Level high for one cycle; returns two negedges later, when a response is visible.
    task automatic pulse(input logic ent, input logic ext);
        car_entry_req = ent;
        car_exit_req  = ext;
        @(negedge CLK);
        car_entry_req = 1'b0;
        car_exit_req  = 1'b0;
        @(negedge CLK);
    endtask

    task automatic start_entry();
        exp_q.push_back({2'b01, model_occ});
        pulse(1'b1, 1'b0);
`ifdef PARKING_PASSCODE_EN
        code_in    = 4'hA;
        code_valid = 1'b1;
        @(negedge CLK);
        code_valid = 1'b0;
`endif
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (gate_busy && n < 400) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_idle timeout actual=busy expected=idle");
        end
    endtask

    task automatic do_entry();
        start_entry();
        wait_idle(cyc);
        check("entry_open_cycles", cyc, 50);
        model_occ = model_occ + 4'd1;
        check("entry_occupancy", occupancy, model_occ);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        model_occ = 4'd0;
    endtask

    initial begin
        RST_N = 1'b0;
        car_entry_req = 1'b0;
        car_exit_req  = 1'b0;
        code_in       = 4'h0;
        code_valid    = 1'b0;
        model_occ     = 4'd0;
        repeat (3) @(negedge CLK);
        check("rst_door_open", door_open, 0);
        check("rst_gate_busy", gate_busy, 0);
        check("rst_full", full, 0);
        check("rst_denied", denied, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_state", fsm_state, IDLE);
        RST_N = 1'b1;

        fork
            forever begin
                @(negedge CLK);
                if (RST_N && (door_open || denied)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse actual=%b expected=none", {denied, door_open, occupancy});
                    end else begin
                        logic [5:0] e;
                        e = exp_q.pop_front();
                        if ({denied, door_open, occupancy} != e) begin
                            errors++;
                            $display("FAIL pulse actual=%b expected=%b", {denied, door_open, occupancy}, e);
                        end
                    end
                end
            end
        join_none

        // Single entry with latency check.
`ifndef PARKING_PASSCODE_EN
        exp_q.push_back({2'b01, 4'd0});
        car_entry_req = 1'b1;
        @(negedge CLK);
        car_entry_req = 1'b0;
        check("latency_early", door_open, 0);
        @(negedge CLK);
        check("latency_door", door_open, 1);
        check("latency_busy", gate_busy, 1);
        wait_idle(cyc);
        check("first_open_cycles", cyc, 50);
        check("first_occupancy", occupancy, 1);
        model_occ = 4'd1;
`else
        do_entry();
`endif

        // Fill to capacity, then a refused entry.
        for (int i = 0; i < 9; i++) do_entry();
        check("cap_occupancy", occupancy, 10);
        check("cap_full", full, 1);
        exp_q.push_back({2'b10, 4'd10});
        pulse(1'b1, 1'b0);
        check("refused_busy", gate_busy, 0);
        repeat (3) @(negedge CLK);
        check("refused_occupancy", occupancy, 10);
        check("refused_full", full, 1);

        // Exit at zero is ignored; simultaneous edges favour exit.
        do_reset();
        check("reset_occupancy", occupancy, 0);
        pulse(1'b0, 1'b1);
        check("exit_at_zero_busy", gate_busy, 0);
        repeat (3) @(negedge CLK);
        check("exit_at_zero_occ", occupancy, 0);
        for (int i = 0; i < 3; i++) do_entry();
        exp_q.push_back({2'b01, 4'd3});
        pulse(1'b1, 1'b1);
        check("both_state", fsm_state, EXIT_OPEN);
        wait_idle(cyc);
        check("exit_open_cycles", cyc, 50);
        check("both_occupancy", occupancy, 2);
        check("both_full", full, 0);
        model_occ = 4'd2;

        // Edges while busy are dropped.
        start_entry();
        repeat (10) @(negedge CLK);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_idle(cyc);
        check("busy_drop_occupancy", occupancy, 3);

        // Asynchronous reset mid-open.
        model_occ = 4'd3;
        start_entry();
        repeat (5) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_door_open", door_open, 0);
        check("midrst_busy", gate_busy, 0);
        check("midrst_occupancy", occupancy, 0);
        check("midrst_full", full, 0);
        check("midrst_state", fsm_state, IDLE);
        @(negedge CLK);
        RST_N = 1'b1;
        model_occ = 4'd0;
        do_entry();

`ifdef PARKING_PASSCODE_EN
        // Wrong code and keypad timeout both deny.
        exp_q.push_back({2'b10, 4'd1});
        pulse(1'b1, 1'b0);
        code_in    = 4'h3;
        code_valid = 1'b1;
        @(negedge CLK);
        code_valid = 1'b0;
        check("badcode_busy", gate_busy, 0);
        exp_q.push_back({2'b10, 4'd1});
        pulse(1'b1, 1'b0);
        wait_idle(cyc);
        check("timeout_cycles", cyc, 100);
        repeat (2) @(negedge CLK);
        check("passcode_occupancy", occupancy, 1);
`endif

        repeat (5) @(negedge CLK);
        check("pending_pulses", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
